uart_register_port: RTL and testbench

- Peripheral-side responder on the ulisp register bus; it is the other end of the bus the core drives.
- Register 0 write queues a byte for serial transmission; other indices expose status and control.
- It is the synthesizable replacement for the simulation-only console at register 0.
- Sits beside the ulisp core in the top level and drives the board UART TX pin (8N1, LSB first).

---
 rtl/ulisp_io_pkg.sv | 31 +++
 rtl/sync_fifo.sv | 68 ++++++
 rtl/uart_register_port.sv | 259 +++++++++++++++++++++++++
 tb/tb_uart_register_port.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/ulisp_io_pkg.sv
// ulisp_io_pkg: shared definitions for the ulisp register-bus UART port.
//   - register indices decoded by uart_register_port
//   - bit positions inside the status / level read words
//   - transmit and receive state encodings
package ulisp_io_pkg;

    localparam logic [11:0] REG_DATA   = 12'd0;
    localparam logic [11:0] REG_STATUS = 12'd1;
    localparam logic [11:0] REG_LEVEL  = 12'd2;

    localparam int ST_TX_FULL     = 0;
    localparam int ST_TX_BUSY     = 1;
    localparam int ST_TX_OVERFLOW = 2;
    localparam int ST_RX_OVERRUN  = 3;
    localparam int ST_RX_VALID    = 8;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO holding bytes waiting for the UART transmitter.
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset (flushes the FIFO)
//   push, push_data     write request and data; ignored when full unless a pop
//                       happens in the same cycle
//   pop, pop_data       read request; pop_data always shows the head entry
//   full, empty, count  occupancy flags and entry count (0..DEPTH)
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);
    localparam logic [AW:0]   CNT_ONE    = (AW + 1)'(1);
    localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == FULL_COUNT);
    assign empty    = (count == '0);
    assign do_pop   = pop && !empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_register_port.sv
// uart_register_port: register-bus responder that serialises bytes onto the
// board UART TX pin (8N1, LSB first).
// Ports:
//   clk, reset_n               clock, asynchronous active-low reset
//   register_index/read/write  bus address and one-cycle strobes from the core
//   register_write_value       write data
//   register_read_value        registered read data, held until the next read
//   uart_tx                    serial output, idle high
//   uart_rx                    serial input, only used when UART_RX_EN is defined
// Register map: 0 = TX data (RX data when UART_RX_EN), 1 = status / sticky
// clear, 2 = FIFO occupancy. Optional receiver: define UART_RX_EN.
module uart_register_port
    import ulisp_io_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [11:0] register_index,
    input  logic        register_read,
    input  logic        register_write,
    input  logic [15:0] register_write_value,
    output logic [15:0] register_read_value,
    output logic        uart_tx,
    input  logic        uart_rx
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BAUD_ONE  = BW'(1);

    logic            is_data, is_status, is_level;
    logic            fifo_push, fifo_pop, tx_full, fifo_empty;
    logic [7:0]      pop_data;
    logic [CW-1:0]   fifo_count;
    logic            tx_busy, tx_overflow;
    logic            rx_valid, rx_overrun;
    logic [7:0]      rx_byte;
    logic [15:0]     status_word, level_word, read_mux;

    tx_state_t       state;
    logic [BW-1:0]   baud;
    logic [2:0]      bit_idx;
    logic [7:0]      shift;

    assign is_data   = (register_index == REG_DATA);
    assign is_status = (register_index == REG_STATUS);
    assign is_level  = (register_index == REG_LEVEL);
    assign fifo_push = register_write && is_data;
    assign fifo_pop  = (state == TX_IDLE) && !fifo_empty;
    assign tx_busy   = (state != TX_IDLE) || !fifo_empty;

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (fifo_push),
        .push_data (register_write_value[7:0]),
        .pop       (fifo_pop),
        .pop_data  (pop_data),
        .full      (tx_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Transmitter. IDLE lasts exactly one cycle between queued bytes, so
    // consecutive frames are separated by a single idle-high clock.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= TX_IDLE;
            baud    <= '0;
            bit_idx <= '0;
            shift   <= '0;
            uart_tx <= 1'b1;
        end else begin
            case (state)
                TX_IDLE: begin
                    baud    <= '0;
                    uart_tx <= 1'b1;
                    if (fifo_pop) begin
                        shift   <= pop_data;
                        bit_idx <= '0;
                        uart_tx <= 1'b0;
                        state   <= TX_START;
                    end
                end
                TX_START: begin
                    if (baud == BAUD_LAST) begin
                        baud    <= '0;
                        uart_tx <= shift[0];
                        state   <= TX_DATA;
                    end else begin
                        baud <= baud + BAUD_ONE;
                    end
                end
                TX_DATA: begin
                    if (baud == BAUD_LAST) begin
                        baud <= '0;
                        if (bit_idx == 3'd7) begin
                            uart_tx <= 1'b1;
                            state   <= TX_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            shift   <= {1'b0, shift[7:1]};
                            uart_tx <= shift[1];
                        end
                    end else begin
                        baud <= baud + BAUD_ONE;
                    end
                end
                TX_STOP: begin
                    if (baud == BAUD_LAST) begin
                        baud  <= '0;
                        state <= TX_IDLE;
                    end else begin
                        baud <= baud + BAUD_ONE;
                    end
                end
                default: state <= TX_IDLE;
            endcase
        end
    end

    // Overflow only when the push is really lost (no pop in the same cycle).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_overflow <= 1'b0;
        end else if (register_write && is_status && register_write_value[ST_TX_OVERFLOW]) begin
            tx_overflow <= 1'b0;
        end else if (fifo_push && tx_full && !fifo_pop) begin
            tx_overflow <= 1'b1;
        end
    end

`ifdef UART_RX_EN
    localparam logic [BW-1:0] BAUD_HALF = BW'(CLKS_PER_BIT / 2 - 1);

    rx_state_t       rx_state;
    logic [1:0]      rx_sync;
    logic [BW-1:0]   rx_baud;
    logic [2:0]      rx_bit;
    logic [7:0]      rx_shift;
    logic            rx_done;
    logic            rx_read;
    logic            unused_inputs;

    assign rx_read       = register_read && is_data;
    assign unused_inputs = ^register_write_value[15:8];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_sync <= 2'b11;
        end else begin
            rx_sync <= {rx_sync[0], uart_rx};
        end
    end

    // Receiver: half a bit after the falling edge the start bit is re-checked
    // (glitches are discarded); from then on samples land mid-bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_state <= RX_IDLE;
            rx_baud  <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
            rx_done  <= 1'b0;
        end else begin
            rx_done <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    rx_baud <= '0;
                    if (!rx_sync[1]) rx_state <= RX_START;
                end
                RX_START: begin
                    if (rx_baud == BAUD_HALF) begin
                        rx_baud  <= '0;
                        rx_bit   <= '0;
                        rx_state <= rx_sync[1] ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_baud <= rx_baud + BAUD_ONE;
                    end
                end
                RX_DATA: begin
                    if (rx_baud == BAUD_LAST) begin
                        rx_baud  <= '0;
                        rx_shift <= {rx_sync[1], rx_shift[7:1]};
                        if (rx_bit == 3'd7) rx_state <= RX_STOP;
                        else rx_bit <= rx_bit + 3'd1;
                    end else begin
                        rx_baud <= rx_baud + BAUD_ONE;
                    end
                end
                RX_STOP: begin
                    if (rx_baud == BAUD_LAST) begin
                        rx_baud  <= '0;
                        rx_done  <= 1'b1;
                        rx_state <= RX_IDLE;
                    end else begin
                        rx_baud <= rx_baud + BAUD_ONE;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_byte    <= '0;
            rx_valid   <= 1'b0;
            rx_overrun <= 1'b0;
        end else begin
            if (rx_done) begin
                rx_byte  <= rx_shift;
                rx_valid <= 1'b1;
                if (rx_valid && !rx_read) rx_overrun <= 1'b1;
            end else if (rx_read) begin
                rx_valid <= 1'b0;
            end
            if (register_write && is_status && register_write_value[ST_RX_OVERRUN]) begin
                rx_overrun <= 1'b0;
            end
        end
    end
`else
    logic unused_inputs;

    assign unused_inputs = ^{register_write_value[15:8], uart_rx};
    assign rx_valid      = 1'b0;
    assign rx_overrun    = 1'b0;
    assign rx_byte       = '0;
`endif

    always_comb begin
        status_word                 = '0;
        status_word[ST_TX_FULL]     = tx_full;
        status_word[ST_TX_BUSY]     = tx_busy;
        status_word[ST_TX_OVERFLOW] = tx_overflow;
        status_word[ST_RX_OVERRUN]  = rx_overrun;
        status_word[ST_RX_VALID]    = rx_valid;
        level_word                  = 16'(fifo_count);
        level_word[ST_RX_VALID]     = rx_valid;
        read_mux                    = '0;
        if (is_data) read_mux = {8'b0, rx_byte};
        else if (is_status) read_mux = status_word;
        else if (is_level) read_mux = level_word;
    end

    // The read captures the state before any write in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            register_read_value <= '0;
        end else if (register_read) begin
            register_read_value <= read_mux;
        end
    end

endmodule

// File: tb/tb_uart_register_port.sv
// tb_uart_register_port: directed and random stimulus for uart_register_port
// (default build, receiver disabled) checked against a transaction-level model
// of the TX queue and a timeline model of the serial line.
module tb_uart_register_port;

    localparam int CPB   = 4;
    localparam int DEPTH = 8;
    localparam int FRAME = 10 * CPB;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [11:0] register_index = '0;
    logic        register_read = 1'b0;
    logic        register_write = 1'b0;
    logic [15:0] register_write_value = '0;
    logic [15:0] register_read_value;
    logic        uart_tx;
    logic        uart_rx = 1'b1;

    int checks = 0;
    int errors = 0;

    logic [11:0] idx_tab [7] = '{12'd0, 12'd1, 12'd2, 12'd3, 12'h101, 12'hFFF, 12'h800};

    uart_register_port #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk                  (clk),
        .reset_n              (reset_n),
        .register_index       (register_index),
        .register_read        (register_read),
        .register_write       (register_write),
        .register_write_value (register_write_value),
        .register_read_value  (register_read_value),
        .uart_tx              (uart_tx),
        .uart_rx              (uart_rx)
    );

    always #5 clk = ~clk;

    // Reference model: queue of accepted bytes, plus the edge number at which
    // the current frame left the queue. The line level is derived from the
    // time elapsed since that edge.
    logic [7:0]  m_q [$];
    logic        m_overflow = 1'b0;
    int          m_cycle = 0;
    int          m_frame_start = -1;
    logic [7:0]  m_frame_byte = '0;
    logic [15:0] m_exp_read = '0;

    function automatic bit line_active(input int c);
        return (m_frame_start >= 0) && (c >= m_frame_start) && (c - m_frame_start < FRAME);
    endfunction

    function automatic logic exp_tx();
        int k;
        int slot;
        if (!line_active(m_cycle)) return 1'b1;
        k    = m_cycle - m_frame_start;
        slot = k / CPB;
        if (slot == 0) return 1'b0;
        if (slot == 9) return 1'b1;
        return m_frame_byte[slot-1];
    endfunction

    always @(posedge clk or negedge reset_n) begin
        bit busy;
        bit pop_now;
        int level;
        if (!reset_n) begin
            m_q.delete();
            m_overflow    = 1'b0;
            m_cycle       = 0;
            m_frame_start = -1;
            m_frame_byte  = '0;
            m_exp_read    = '0;
        end else begin
            m_cycle++;
            level   = m_q.size();
            busy    = (level > 0) || line_active(m_cycle - 1);
            pop_now = (level > 0) && !line_active(m_cycle - 1);
            if (register_read) begin
                case (register_index)
                    12'd1:   m_exp_read = {12'b0, 1'b0, m_overflow, busy, level == DEPTH};
                    12'd2:   m_exp_read = 16'(level);
                    default: m_exp_read = 16'h0000;
                endcase
            end
            if (register_write && register_index == 12'd0) begin
                if (level < DEPTH || pop_now) m_q.push_back(register_write_value[7:0]);
                else m_overflow = 1'b1;
            end
            if (register_write && register_index == 12'd1 && register_write_value[2]) begin
                m_overflow = 1'b0;
            end
            if (pop_now) begin
                m_frame_byte  = m_q.pop_front();
                m_frame_start = m_cycle;
            end
        end
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One bus cycle: drive at the falling edge, let the rising edge act,
    // then compare line and read data at the next falling edge.
    task automatic step(input logic rd, input logic wr, input logic [11:0] idx,
                        input logic [15:0] wdata);
        register_read        = rd;
        register_write       = wr;
        register_index       = idx;
        register_write_value = wdata;
        @(posedge clk);
        @(negedge clk);
        register_read        = 1'b0;
        register_write       = 1'b0;
        register_index       = '0;
        register_write_value = '0;
        check("uart_tx", {15'b0, uart_tx}, {15'b0, exp_tx()});
        check("read_value", register_read_value, m_exp_read);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 12'd0, 16'h0000);
    endtask

    initial begin
        // Reset state
        #3 reset_n = 1'b0;
        #1;
        check("reset_tx", {15'b0, uart_tx}, 16'h0001);
        check("reset_read", register_read_value, 16'h0000);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        idle(6);
        step(1'b1, 1'b0, 12'd1, 16'h0000);
        check("status_after_reset", register_read_value, 16'h0000);

        // Single frame 0x55: start two cycles after the strobe, 40-cycle frame
        step(1'b0, 1'b1, 12'd0, 16'h0155);
        check("high_after_push", {15'b0, uart_tx}, 16'h0001);
        idle(1);
        check("start_bit", {15'b0, uart_tx}, 16'h0000);
        idle(9 * CPB - 1);
        check("last_data_bit", {15'b0, uart_tx}, 16'h0000);
        idle(CPB);
        check("stop_bit", {15'b0, uart_tx}, 16'h0001);
        step(1'b1, 1'b0, 12'd1, 16'h0000);
        check("busy_in_stop", register_read_value, 16'h0002);
        step(1'b1, 1'b0, 12'd1, 16'h0000);
        check("idle_after_frame", register_read_value, 16'h0000);

        // Nine back-to-back writes fit, the tenth overflows, then clear
        for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 12'd0, 16'($urandom_range(0, 65535)));
        step(1'b1, 1'b0, 12'd1, 16'h0000);
        check("nine_accepted", register_read_value, 16'h0003);
        step(1'b1, 1'b0, 12'd2, 16'h0000);
        check("level_full", register_read_value, 16'd8);
        step(1'b0, 1'b1, 12'd0, 16'h00AA);
        step(1'b1, 1'b0, 12'd1, 16'h0000);
        check("overflow_set", register_read_value, 16'h0007);
        step(1'b0, 1'b1, 12'd1, 16'h0004);
        step(1'b1, 1'b0, 12'd1, 16'h0000);
        check("overflow_clear", register_read_value, 16'h0003);
        idle(9 * (FRAME + 1) + 10);

        // Two queued bytes: one idle clock between stop and next start
        step(1'b0, 1'b1, 12'd0, 16'h0041);
        step(1'b0, 1'b1, 12'd0, 16'h0042);
        idle(FRAME);
        check("frame_gap_high", {15'b0, uart_tx}, 16'h0001);
        idle(1);
        check("second_start", {15'b0, uart_tx}, 16'h0000);
        idle(FRAME + 5);

        // Reset in the middle of a data bit
        step(1'b0, 1'b1, 12'd0, 16'h0000);
        step(1'b0, 1'b1, 12'd0, 16'h003C);
        idle(8);
        check("data_low", {15'b0, uart_tx}, 16'h0000);
        reset_n = 1'b0;
        #1;
        check("reset_async_tx", {15'b0, uart_tx}, 16'h0001);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        step(1'b1, 1'b0, 12'd2, 16'h0000);
        check("level_after_reset", register_read_value, 16'h0000);
        idle(3);

        // Random traffic against the model
        for (int i = 0; i < 1500; i++) begin
            int          op;
            logic [11:0] ridx;
            logic [15:0] data;
            op   = $urandom_range(0, 9);
            ridx = idx_tab[$urandom_range(0, 6)];
            data = 16'($urandom_range(0, 65535));
            case (op)
                0, 1, 2: step(1'b0, 1'b1, 12'd0, data);
                3:       step(1'b1, 1'b0, ridx, 16'h0000);
                4:       step(1'b0, 1'b1, ridx, data);
                5:       step(1'b1, 1'b1, 12'd0, data);
                6:       step(1'b1, 1'b1, 12'd1, data);
                default: step(1'b0, 1'b0, 12'd0, 16'h0000);
            endcase
        end
        idle(DEPTH * (FRAME + 1) + 20);
        step(1'b1, 1'b0, 12'd2, 16'h0000);
        check("drained", register_read_value, 16'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
